// File: rtl/cga_mem_responder.sv
// rtl/cga_mem_responder.sv - memory-side responder: single/double word cycles with wait states and odd parity
module cga_mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic        DOUBLE,
    input  logic        SHADOW,
    input  logic [13:0] LA_23_10,
    input  logic [9:0]  ADDR_9_0,
    input  logic [15:0] WDATA,
    input  logic [15:0] WDATA2,
    input  logic        PARCLR,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_PAR_IN,
    output logic        BUSY,
    output logic        RDY,
    output logic [15:0] RDATA,
    output logic [15:0] RDATA2,
    output logic        PARERR,
    output logic [23:0] PERR_ADDR,
    output logic [23:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        MEM_PAR_OUT,
    output logic        MEM_OE,
    output logic        MEM_WE,
    output logic        MEM_SHADOW
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        is_write;
    logic        is_double;
    logic        second_word;
    logic [15:0] wdata2_q;
    logic [15:0] rdata1_q;
    logic        rd_bad;

    // Odd parity: a good word has an odd number of ones across data plus parity bit.
    assign rd_bad = ~(^{MEM_RDATA, MEM_PAR_IN});

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            is_write    <= 1'b0;
            is_double   <= 1'b0;
            second_word <= 1'b0;
            wdata2_q    <= 16'd0;
            rdata1_q    <= 16'd0;
            BUSY        <= 1'b0;
            RDY         <= 1'b0;
            RDATA       <= 16'd0;
            RDATA2      <= 16'd0;
            PARERR      <= 1'b0;
            PERR_ADDR   <= 24'd0;
            MEM_ADDR    <= 24'd0;
            MEM_WDATA   <= 16'd0;
            MEM_PAR_OUT <= 1'b0;
            MEM_OE      <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_SHADOW  <= 1'b0;
        end else begin
            if (PARCLR)
                PARERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (MREQ) begin
                        MEM_ADDR    <= {LA_23_10, ADDR_9_0};
                        MEM_WDATA   <= WDATA;
                        MEM_PAR_OUT <= ~^WDATA;
                        MEM_SHADOW  <= SHADOW;
                        wdata2_q    <= WDATA2;
                        is_write    <= WRITE;
                        is_double   <= DOUBLE;
                        second_word <= 1'b0;
                        BUSY        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= 4'd0;
                    MEM_OE   <= ~is_write;
                    MEM_WE   <= is_write;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == LAST_WAIT) begin
                        MEM_OE <= 1'b0;
                        MEM_WE <= 1'b0;
                        if (!is_write) begin
                            // A new error overrides a same-edge clear; otherwise the first address sticks.
                            if (rd_bad && (!PARERR || PARCLR)) begin
                                PARERR    <= 1'b1;
                                PERR_ADDR <= MEM_ADDR;
                            end
                            if (is_double && !second_word) begin
                                rdata1_q <= MEM_RDATA;
                            end else if (is_double) begin
                                RDATA  <= rdata1_q;
                                RDATA2 <= MEM_RDATA;
                            end else begin
                                RDATA <= MEM_RDATA;
                            end
                        end
                        if (is_double && !second_word) begin
                            second_word <= 1'b1;
                            MEM_ADDR    <= MEM_ADDR + 24'd1;
                            MEM_WDATA   <= wdata2_q;
                            MEM_PAR_OUT <= ~^wdata2_q;
                            state       <= SETUP;
                        end else begin
                            RDY   <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    RDY   <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
